// File: rtl/btn_press_classifier.sv
// btn_press_classifier
//   Turns a debounced, clk-synchronous button level into single-cycle event
//   pulses: press, release, short click, long hold and double click.
//   Optional feature macro: AUTO_REPEAT_EN. When it is defined, repeat_pulse
//   fires periodically while the button is long-held. When it is not defined,
//   repeat_pulse is tied low and no repeat counter is built. The port list is
//   the same in both builds.
//
//   Timing reference: T is the first posedge that samples btn_in=1. Outputs
//   are registered, so a decision taken at an edge becomes visible in the
//   following cycle. The entry edge of a state counts as the first cycle spent
//   in that state. cnt reads 0 after that edge, so a threshold of N cycles is
//   met when cnt == N-2 at the deciding edge.
module btn_press_classifier #(
  parameter int LONG_CYCLES       = 50_000_000,
  parameter int DOUBLE_GAP_CYCLES = 31_250_000,
  parameter int REPEAT_CYCLES     = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_held,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic repeat_pulse
);

  localparam int MAX_LG = (LONG_CYCLES > DOUBLE_GAP_CYCLES) ? LONG_CYCLES : DOUBLE_GAP_CYCLES;
  localparam int MAX_P  = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 2);
  localparam logic [CW-1:0] GAP_LAST  = CW'(DOUBLE_GAP_CYCLES - 2);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESSED   = 3'd1,
    S_LONG_HELD = 3'd2,
    S_WAIT_GAP  = 3'd3,
    S_SECOND    = 3'd4
  } state_t;

  state_t          state;
  state_t          state_d;
  logic            btn_q;
  logic [CW-1:0]   cnt;
  logic            rise;
  logic            fall;
  logic            state_change;

  logic            short_d;
  logic            long_d;
  logic            double_d;
  logic            repeat_d;

  assign rise         = btn_in & ~btn_q;
  assign fall         = ~btn_in & btn_q;
  assign state_change = (state_d != state);
  assign btn_held     = btn_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; a fall beats the long threshold, a rise beats the gap timeout
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (rise) state_d = S_PRESSED;
      end
      S_PRESSED: begin
        if (fall)                          state_d = S_WAIT_GAP;
        else if (btn_in && cnt == LONG_LAST) state_d = S_LONG_HELD;
      end
      S_LONG_HELD: begin
        if (fall) state_d = S_IDLE;
      end
      S_WAIT_GAP: begin
        if (rise)                  state_d = S_SECOND;
        else if (cnt == GAP_LAST)  state_d = S_IDLE;
      end
      S_SECOND: begin
        if (fall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Classification decisions; at most one of these is set in any cycle
  always_comb begin
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    case (state)
      S_PRESSED:  long_d   = btn_in && !fall && (cnt == LONG_LAST);
      S_WAIT_GAP: begin
        double_d = rise;
        short_d  = !rise && (cnt == GAP_LAST);
      end
      default: ;
    endcase
  end

  // In-state cycle counter: cleared on every state change, saturating otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_change) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0] rcnt;

  // Repeat period counter: restarts on entry to LONG_HELD and after each repeat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
    end else if (state != S_LONG_HELD || rcnt == REP_LAST) begin
      rcnt <= '0;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // Repeat fires only while the button stays held; a sampled fall suppresses it
  always_comb begin
    repeat_d = (state == S_LONG_HELD) && !fall && (rcnt == REP_LAST);
  end

  // Repeat output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= repeat_d;
    end
  end
`else
  assign repeat_d     = 1'b0;
  assign repeat_pulse = repeat_d;
`endif

  // Input sample and registered event outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      double_pulse  <= 1'b0;
    end else begin
      btn_q         <= btn_in;
      press_pulse   <= rise;
      release_pulse <= fall;
      short_pulse   <= short_d;
      long_pulse    <= long_d;
      double_pulse  <= double_d;
    end
  end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Bench for btn_press_classifier with LONG=8, GAP=6, REPEAT=4.
// Each test is a per-cycle plan: button level, reset level and the pulses
// expected to be visible after that cycle's posedge. The driver pushes the
// expected output vector into exp_q. The monitor pops one entry and compares
// it 1 time unit after every posedge.
module tb_btn_press_classifier;

  localparam int PLEN = 40;
  localparam int B_PRESS = 5, B_REL = 4, B_SHORT = 3, B_LONG = 2, B_DBL = 1, B_REP = 0;

  logic clk;
  logic rst_n;
  logic btn_in;
  logic btn_held, press_pulse, release_pulse, short_pulse, long_pulse, double_pulse, repeat_pulse;
  logic [6:0] dut_vec;

  logic [6:0] exp_q[$];
  int n_vec;
  int n_err;

  logic       wave  [0:PLEN-1];
  logic       rwave [0:PLEN-1];
  logic [5:0] pmark [0:PLEN-1];

  btn_press_classifier #(
    .LONG_CYCLES(8),
    .DOUBLE_GAP_CYCLES(6),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .btn_held(btn_held),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .short_pulse(short_pulse),
    .long_pulse(long_pulse),
    .double_pulse(double_pulse),
    .repeat_pulse(repeat_pulse)
  );

  assign dut_vec = {btn_held, press_pulse, release_pulse, short_pulse,
                    long_pulse, double_pulse, repeat_pulse};

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n  = 1'b0;
    btn_in = 1'b0;
  end

  // Monitor: compare one queued vector after every posedge
  initial begin
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (dut_vec !== e) begin
          n_err++;
          $display("FAIL out_vec t=%0t got=%b want=%b (held,press,rel,short,long,dbl,rep)",
                   $time, dut_vec, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic step(input logic b, input logic r, input logic [5:0] p);
    @(negedge clk);
    btn_in = b;
    rst_n  = r;
    if (!r) begin
      #1;
      n_vec++;
      if (dut_vec !== 7'd0) begin
        n_err++;
        $display("FAIL reset_zero t=%0t got=%b want=%b", $time, dut_vec, 7'd0);
      end
    end
    exp_q.push_back(r ? {b, p} : 7'd0);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < PLEN; i++) begin
      wave[i]  = 1'b0;
      rwave[i] = 1'b1;
      pmark[i] = 6'd0;
    end
  endtask

  task automatic set_hi(input int a, input int b);
    for (int i = a; i <= b; i++) wave[i] = 1'b1;
  endtask

  task automatic mark(input int idx, input int bitpos);
    pmark[idx][bitpos] = 1'b1;
  endtask

  task automatic play(input int len);
    for (int i = 0; i < len; i++) step(wave[i], rwave[i], pmark[i]);
  endtask

  // Directed tests
  initial begin
    n_vec = 0;
    n_err = 0;

    // 1: reset held while the button toggles, then a quiet release
    clear_plan();
    for (int i = 0; i < 5; i++) begin
      rwave[i] = 1'b0;
      wave[i]  = logic'(i % 2);
    end
    play(9);

    // 2: short click (high 3 cycles)
    clear_plan();
    set_hi(1, 3);
    mark(1, B_PRESS);
    mark(4, B_REL);
    mark(9, B_SHORT);
    play(14);

    // 3: long hold (high 20 cycles)
    clear_plan();
    set_hi(1, 20);
    mark(1, B_PRESS);
    mark(8, B_LONG);
`ifdef AUTO_REPEAT_EN
    mark(12, B_REP);
    mark(16, B_REP);
    mark(20, B_REP);
`endif
    mark(21, B_REL);
    play(30);

    // 4: double click, high 2 / low 3 / high 2
    clear_plan();
    set_hi(1, 2);
    set_hi(6, 7);
    mark(1, B_PRESS);
    mark(3, B_REL);
    mark(6, B_PRESS);
    mark(6, B_DBL);
    mark(8, B_REL);
    play(16);

    // 5: second rise lands exactly on the gap-timeout edge
    clear_plan();
    set_hi(1, 1);
    set_hi(7, 7);
    mark(1, B_PRESS);
    mark(2, B_REL);
    mark(7, B_PRESS);
    mark(7, B_DBL);
    mark(8, B_REL);
    play(16);

    // 6: reset while pressed at cnt=5, button kept high through reset
    clear_plan();
    set_hi(1, 22);
    rwave[7] = 1'b0;
    rwave[8] = 1'b0;
    mark(1, B_PRESS);
    mark(9, B_PRESS);
    mark(16, B_LONG);
`ifdef AUTO_REPEAT_EN
    mark(20, B_REP);
`endif
    mark(23, B_REL);
    play(30);

    // Final report once the scoreboard has drained
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
